// File: rtl/sync_receiver_pkg.sv
// sync_receiver_pkg: default bus width/depth and the count-width helper
// shared by the receiver and its buffer.
package sync_receiver_pkg;
    localparam int DEF_B = 4;
    localparam int DEF_D = 4;

    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through buffer; storage, pointers and occupancy count.
module sync_fifo
    import sync_receiver_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int D = DEF_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [B-1:0]          din,
    output logic [B-1:0]          dout,
    output logic [cnt_w(D)-1:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(D);
    localparam int CW = cnt_w(D);

    logic [B-1:0]  r_mem [D];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // D is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(D));
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/sync_receiver.sv
// sync_receiver: rqst/ack word receiver with a registered acknowledge,
// feeding a first-word-fall-through buffer drained by dvalid/dready.
module sync_receiver
    import sync_receiver_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int D = DEF_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rqst,
    input  logic [B-1:0]          BusData,
    output logic                  ack,
    output logic [B-1:0]          dout,
    output logic                  dvalid,
    input  logic                  dready,
    output logic [cnt_w(D)-1:0]   count
);
    localparam int CW = cnt_w(D);

    logic          r_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_next;

    // BusData reaches storage only through w_push, so Z/X outside a push is harmless
    assign w_push = rqst & r_ack & ~w_full & ~rst;
    assign w_pop  = ~w_empty & dready;
    assign w_next = count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        r_ack <= rst ? 1'b0 : (w_next < CW'(D));
    end

    sync_fifo #(.B(B), .D(D)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (BusData),
        .dout  (dout),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign ack    = r_ack;
    assign dvalid = ~w_empty;
endmodule

// File: tb/tb_sync_receiver.sv
// tb_sync_receiver: randomized and directed checks of sync_receiver against
// a queue-based reference model of the receive buffer.
module tb_sync_receiver;
    import sync_receiver_pkg::*;
    localparam int B  = 4;
    localparam int D  = 4;
    localparam int CW = cnt_w(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          rqst;
    logic [B-1:0]  BusData;
    logic          ack;
    logic [B-1:0]  dout;
    logic          dvalid;
    logic          dready;
    logic [CW-1:0] count;

    logic [B-1:0]  q[$];
    logic          m_ack = 1'b0;
    logic          e_dv;
    logic [B-1:0]  e_dout;
    logic [CW-1:0] e_cnt;
    int            vectors = 0;
    int            errs = 0;

    sync_receiver #(.B(B), .D(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .rqst    (rqst),
        .BusData (BusData),
        .ack     (ack),
        .dout    (dout),
        .dvalid  (dvalid),
        .dready  (dready),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the handshake rules to the queue.
    task automatic tick();
        bit p;
        bit o;
        @(posedge clk);
        p = !rst && rqst && m_ack;
        o = !rst && (q.size() > 0) && dready;
        if (rst) q.delete();
        else begin
            if (o) void'(q.pop_front());
            if (p) q.push_back(BusData);
        end
        m_ack = !rst && (q.size() < D);
        #1;
        e_cnt  = CW'(q.size());
        e_dv   = (q.size() != 0);
        e_dout = e_dv ? q[0] : '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rqst = 1'b0; dready = 1'b0; BusData = 'z;
        tick();
        tick();
        vectors++;
        if ({ack, dvalid, dout, count} !== {1'b0, 1'b0, {B{1'b0}}, {CW{1'b0}}}) begin
            $display("FAIL reset_hold: ack=%b dvalid=%b dout=%h count=%0d, expected 0 0 0 0", ack, dvalid, dout, count);
            errs++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({ack, dvalid, dout, count} !== {1'b1, 1'b0, {B{1'b0}}, {CW{1'b0}}}) begin
            $display("FAIL reset_release: ack=%b dvalid=%b dout=%h count=%0d, expected 1 0 0 0", ack, dvalid, dout, count);
            errs++;
        end
    endtask

    task automatic test_single();
        rqst = 1'b1; BusData = 4'hA; dready = 1'b0;
        tick();
        rqst = 1'b0; BusData = 'z;
        vectors++;
        if ({dvalid, dout, count} !== {1'b1, 4'hA, CW'(1)}) begin
            $display("FAIL single_push: dvalid=%b dout=%h count=%0d, expected 1 a 1", dvalid, dout, count);
            errs++;
        end
        dready = 1'b1;
        tick();
        dready = 1'b0;
        vectors++;
        if ({dvalid, dout, count} !== {e_dv, e_dout, e_cnt}) begin
            $display("FAIL single_drain: dvalid=%b dout=%h count=%0d, expected %b %h %0d", dvalid, dout, count, e_dv, e_dout, e_cnt);
            errs++;
        end
    endtask

    task automatic test_fill();
        rqst = 1'b1; dready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            BusData = B'(i);
            tick();
            vectors++;
            if ({ack, dvalid, dout, count} !== {m_ack, e_dv, e_dout, e_cnt}) begin
                $display("FAIL fill_%0d: ack=%b dvalid=%b dout=%h count=%0d, expected %b %b %h %0d", i, ack, dvalid, dout, count, m_ack, e_dv, e_dout, e_cnt);
                errs++;
            end
        end
        vectors++;
        if ({ack, count, dout} !== {1'b0, CW'(4), 4'h1}) begin
            $display("FAIL fill_full: ack=%b count=%0d dout=%h, expected 0 4 1", ack, count, dout);
            errs++;
        end
        dready = 1'b1;
        tick();
        vectors++;
        if ({ack, dout, count} !== {1'b1, 4'h2, CW'(3)}) begin
            $display("FAIL fill_first_pop: ack=%b dout=%h count=%0d, expected 1 2 3", ack, dout, count);
            errs++;
        end
        tick();
        rqst = 1'b0; BusData = 'z;
        vectors++;
        if ({dout, count} !== {4'h3, CW'(3)}) begin
            $display("FAIL fill_accept5: dout=%h count=%0d, expected 3 3", dout, count);
            errs++;
        end
        for (int i = 4; i <= 6; i++) begin
            tick();
            vectors++;
            if ({ack, dvalid, dout, count} !== {m_ack, e_dv, e_dout, e_cnt} || (i <= 5 && dout !== B'(i))) begin
                $display("FAIL fill_drain_%0d: dout=%h count=%0d dvalid=%b, expected %h %0d %b", i, dout, count, dvalid, e_dout, e_cnt, e_dv);
                errs++;
            end
        end
        dready = 1'b0;
    endtask

    task automatic test_back_to_back();
        rqst = 1'b1; dready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            BusData = B'(i);
            tick();
            vectors++;
            if ({ack, dvalid, dout, count} !== {1'b1, 1'b1, B'(i), CW'(1)}) begin
                $display("FAIL stream_%0d: ack=%b dvalid=%b dout=%h count=%0d, expected 1 1 %h 1", i, ack, dvalid, dout, count, B'(i));
                errs++;
            end
        end
        rqst = 1'b0; BusData = 'z;
        tick();
        dready = 1'b0;
        vectors++;
        if ({dvalid, count} !== {1'b0, CW'(0)}) begin
            $display("FAIL stream_drain: dvalid=%b count=%0d, expected 0 0", dvalid, count);
            errs++;
        end
    endtask

    task automatic test_reset_mid();
        rqst = 1'b1; dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BusData = B'($urandom_range(1, 15));
            tick();
        end
        vectors++;
        if (count !== CW'(3)) begin
            $display("FAIL midrst_fill: count=%0d, expected 3", count);
            errs++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; rqst = 1'b0; BusData = 'z;
        vectors++;
        if ({ack, dvalid, dout, count} !== {1'b0, 1'b0, {B{1'b0}}, {CW{1'b0}}}) begin
            $display("FAIL midrst_clear: ack=%b dvalid=%b dout=%h count=%0d, expected 0 0 0 0", ack, dvalid, dout, count);
            errs++;
        end
        dready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({ack, dvalid, dout, count} !== {1'b1, 1'b0, {B{1'b0}}, {CW{1'b0}}}) begin
                $display("FAIL midrst_after_%0d: ack=%b dvalid=%b dout=%h count=%0d, expected 1 0 0 0", i, ack, dvalid, dout, count);
                errs++;
            end
        end
        dready = 1'b0;
    endtask

    task automatic test_bus_z();
        rqst = 1'b1; dready = 1'b0;
        BusData = 4'h6; tick();
        BusData = 4'h9; tick();
        rqst = 1'b0; BusData = 'z;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({dvalid, dout, count} !== {1'b1, 4'h6, CW'(2)} || $isunknown({ack, dvalid, dout, count})) begin
                $display("FAIL busz_%0d: dvalid=%b dout=%h count=%0d ack=%b, expected 1 6 2 1", i, dvalid, dout, count, ack);
                errs++;
            end
        end
        rqst = 1'b0; BusData = 'x;
        tick();
        vectors++;
        if ({dvalid, dout, count} !== {1'b1, 4'h6, CW'(2)}) begin
            $display("FAIL busx: dvalid=%b dout=%h count=%0d, expected 1 6 2", dvalid, dout, count);
            errs++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            rqst    = ($urandom_range(0, 99) < 60);
            dready  = ($urandom_range(0, 99) < 45);
            BusData = rqst ? B'($urandom) : 'z;
            tick();
            vectors++;
            if ({ack, dvalid, dout, count} !== {m_ack, e_dv, e_dout, e_cnt}) begin
                $display("FAIL random_%0d: ack=%b dvalid=%b dout=%h count=%0d, expected %b %b %h %0d", i, ack, dvalid, dout, count, m_ack, e_dv, e_dout, e_cnt);
                errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_bus_z();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/sync_receiver.md
SYNC_RECEIVER -- requirements
Module: sync_receiver

Interface
REQ-001 Parameter B, default 4, SHALL set the data bus width in bits.
REQ-002 Parameter D, default 4, SHALL set the receive buffer depth in words; power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rqst  input  1  SHALL be the sender's request: a word is offered on BusData.
REQ-006 BusData  input  B  SHALL carry the sender's data; valid only while rqst and ack are both high, may be Z otherwise.
REQ-007 ack  output  1  SHALL be the registered acknowledge: the receiver can accept a word this cycle.
REQ-008 dout  output  B  SHALL be the oldest buffered word (first-word-fall-through).
REQ-009 dvalid  output  1  SHALL indicate dout holds a valid word.
REQ-010 dready  input  1  SHALL indicate the downstream consumer takes dout this cycle.
REQ-011 count  output  $clog2(D)+1  SHALL give the number of buffered words, 0..D.

Function
REQ-012 A push SHALL occur at a rising edge where rqst=1 and ack=1; BusData is written at wr_ptr, and wr_ptr advances modulo D.
REQ-013 BusData SHALL be ignored (never sampled) in any cycle without a push, so Z or X on it has no effect.
REQ-014 A pop SHALL occur at a rising edge where dvalid=1 and dready=1; rd_ptr advances modulo D.
REQ-015 dready while dvalid=0 SHALL have no effect.
REQ-016 Next count SHALL be count + push - pop; simultaneous push and pop leave count unchanged.
REQ-017 dvalid SHALL equal (count != 0), decoded from registered state only.
REQ-018 dout SHALL present the word at rd_ptr when dvalid=1, and all-zeros when dvalid=0.
REQ-019 Latency: a word pushed at edge N into an empty buffer SHALL appear on dout with dvalid=1 in the cycle following edge N.
REQ-020 ack SHALL be registered as (next count < D), so it deasserts in the cycle after the edge that fills the buffer.
REQ-021 ack SHALL reassert in the cycle after the edge where a pop brings count below D.
REQ-022 No push SHALL ever occur when count=D; there is no overflow path.
REQ-023 Sustained throughput SHALL be one word per cycle when rqst=1 continuously and dready=1 continuously.
REQ-024 Words SHALL leave in exactly the order they were pushed, across pointer wrap-around.

Reset
REQ-025 While rst=1 at a rising edge: count=0, wr_ptr=0, rd_ptr=0, ack=0; hence dvalid=0 and dout=0.
REQ-026 Storage array contents SHALL NOT require reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; no push occurs in a cycle with rst=1.
REQ-028 ack SHALL first assert in the cycle after the first edge with rst=0.

Structure
REQ-029 Shared package SHALL hold the default width (4) and default depth (4) constants, plus a function computing the count width.
REQ-030 Buffer storage, pointers and count SHALL be a sub-module sync_fifo (push, pop, din, dout, count, full, empty); sync_receiver adds the handshake decode and the registered ack.

Verification (B=4, D=4)
REQ-031 Reset release with rqst=0 -> ack=0 in the reset cycle, ack=1 in the next cycle; dvalid=0, dout=0, count=0.
REQ-032 rqst=1 for one push with BusData=4'hA, dready=0 -> next cycle dvalid=1, dout=4'hA, count=1.
REQ-033 rqst=1 continuously with BusData 1,2,3,4,5, dready=0 -> four pushes, then count=4 and ack=0 the cycle after the 4th push; word 5 not accepted; raise dready -> pops 1,2,3,4 in order, ack=1 the cycle after the first pop, then 5 is accepted.
REQ-034 rqst=1 and dready=1 continuously for 10 words 0..9 -> one word per cycle, count constant at 1 after the first push, pointers wrap, output order 0..9.
REQ-035 Buffer holding 3 words, rst pulsed for one cycle -> next cycle count=0, dvalid=0, dout=0; the old words never appear on dout.
REQ-036 BusData=Z with rqst=0 for 5 cycles -> count, dout and dvalid unchanged; no X propagates to the outputs.
